mux_16: RTL and testbench

- 16-to-1 single-bit multiplexer. Selects one bit of a 16-bit input vector using a 4-bit index.
- Provides a purely combinational output plus a registered copy for pipelined consumers.
- Also provides a one-hot decode of the select.
- Leaf datapath primitive used wherever a bit must be picked from a 16-bit bus.

---
 rtl/mux_16_if.sv | 31 +++
 rtl/mux_16.sv | 69 ++++++
 tb/tb_mux_16.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mux_16_if.sv
// mux_16_if -- signal bundle for the 16-to-1 bit selector.
//
// Signals:
//   en      : capture enable for the registered output
//   in      : 16-bit data vector, bit 0 is the LSB
//   sel     : 4-bit unsigned index into in
//   out     : combinational in[sel]
//   out_q   : registered in[sel]
//   sel_dec : combinational one-hot decode of sel
//
// Modports:
//   master : drives en/in/sel, observes the results
//   slave  : the selector itself
interface mux_16_if;
   logic        en;
   logic [15:0] in;
   logic [3:0]  sel;
   logic        out;
   logic        out_q;
   logic [15:0] sel_dec;

   modport master (
      output en, in, sel,
      input  out, out_q, sel_dec
   );

   modport slave (
      input  en, in, sel,
      output out, out_q, sel_dec
   );
endinterface

// File: rtl/mux_16.sv
// mux_16 -- 16-to-1 single-bit multiplexer with registered copy and
// one-hot select decode.
//
// Ports:
//   clk : system clock, rising edge updates out_q
//   rst : synchronous active-high reset, clears out_q only
//   bus : mux_16_if.slave
//           en, in[15:0], sel[3:0]   inputs
//           out      = in[sel], combinational, zero latency
//           out_q    = in[sel] captured on an enabled edge, one cycle latency
//           sel_dec  = one-hot decode of sel, combinational
//
// The selection is built as a balanced tree of 2:1 muxes, one tree level
// per select bit, LSB first. out and sel_dec carry no state and never see
// clk or rst, so they are valid before any clock or reset is applied.
module mux_16 (
   input  logic     clk,
   input  logic     rst,
   mux_16_if.slave  bus
);

   function automatic logic mux2(input logic s, input logic a0, input logic a1);
      return s ? a1 : a0;
   endfunction

   logic [7:0] lvl1;
   logic [3:0] lvl2;
   logic [1:0] lvl3;
   logic       lvl4;
   logic [15:0] dec;
   logic        out_q_r;

   // Level 1: sel[0] picks between adjacent bit pairs.
   for (genvar i = 0; i < 8; i++) begin : g_lvl1
      assign lvl1[i] = mux2(bus.sel[0], bus.in[2*i], bus.in[2*i+1]);
   end

   // Level 2: sel[1].
   for (genvar i = 0; i < 4; i++) begin : g_lvl2
      assign lvl2[i] = mux2(bus.sel[1], lvl1[2*i], lvl1[2*i+1]);
   end

   // Level 3: sel[2].
   for (genvar i = 0; i < 2; i++) begin : g_lvl3
      assign lvl3[i] = mux2(bus.sel[2], lvl2[2*i], lvl2[2*i+1]);
   end

   // Level 4: sel[3] chooses between the lower and upper byte results.
   assign lvl4 = mux2(bus.sel[3], lvl3[0], lvl3[1]);

   // All 16 codes are legal, so exactly one bit is ever set.
   for (genvar k = 0; k < 16; k++) begin : g_dec
      assign dec[k] = (bus.sel == 4'(k));
   end

   // Registered copy; reset wins over enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q_r <= 1'b0;
      end else if (bus.en) begin
         out_q_r <= lvl4;
      end
   end

   assign bus.out     = lvl4;
   assign bus.sel_dec = dec;
   assign bus.out_q   = out_q_r;

endmodule

// File: tb/tb_mux_16.sv
// tb_mux_16 -- directed self-checking bench for mux_16.
module tb_mux_16;

   logic clk;
   logic rst;
   logic clk_run;

   int checks;
   int errors;

   mux_16_if bus ();

   mux_16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] v;
      logic [15:0] bad_in;
      logic [3:0]  bad_sel;
      logic        bad_out;
      logic        bad_exp;
      logic        found;

      checks  = 0;
      errors  = 0;
      clk_run = 1'b0;
      rst     = 1'b0;
      bus.en  = 1'b0;
      bus.in  = 16'h0000;
      bus.sel = 4'd0;

      // No clock, no reset: combinational paths only.
      bus.in  = 16'hA5A5;
      bus.sel = 4'd2;
      #1;
      chk("noclk_sel2_out", 16'(bus.out), 16'h0001);
      chk("noclk_sel2_dec", bus.sel_dec, 16'h0004);
      bus.sel = 4'd1;
      #1;
      chk("noclk_sel1_out", 16'(bus.out), 16'h0000);
      bus.sel = 4'd15;
      #1;
      chk("noclk_sel15_out", 16'(bus.out), 16'h0001);
      chk("noclk_sel15_dec", bus.sel_dec, 16'h8000);

      // Exhaustive sweep, stopping at the first mismatch.
      found   = 1'b0;
      bad_in  = '0;
      bad_sel = '0;
      bad_out = 1'b0;
      bad_exp = 1'b0;
      for (int i = 0; i < 65536 && !found; i++) begin
         for (int s = 0; s < 16 && !found; s++) begin
            v       = i[15:0];
            bus.in  = v;
            bus.sel = s[3:0];
            #1;
            if (bus.out !== v[s]) begin
               found   = 1'b1;
               bad_in  = v;
               bad_sel = s[3:0];
               bad_out = bus.out;
               bad_exp = v[s];
            end
         end
      end
      if (found)
         $display("exhaustive first mismatch at in=%0h sel=%0d", bad_in, bad_sel);
      chk("exhaustive_first_bad", 16'(bad_out), 16'(bad_exp));

      // Walking one with full select sweep.
      for (int k = 0; k < 16; k++) begin
         for (int s = 0; s < 16; s++) begin
            bus.in  = 16'h0001 << k;
            bus.sel = s[3:0];
            #1;
            chk($sformatf("walk_out_k%0d_s%0d", k, s), 16'(bus.out), (k == s) ? 16'h0001 : 16'h0000);
            chk($sformatf("walk_dec_s%0d", s), bus.sel_dec, 16'h0001 << s);
         end
      end

      // Start the clock for the registered path.
      clk_run = 1'b1;

      // Reset has priority over enable.
      rst     = 1'b1;
      bus.en  = 1'b1;
      bus.in  = 16'hFFFF;
      bus.sel = 4'd5;
      tick();
      chk("rst_priority", 16'(bus.out_q), 16'h0000);
      chk("rst_out_comb", 16'(bus.out), 16'h0001);
      rst = 1'b0;
      tick();
      chk("post_rst_capture", 16'(bus.out_q), 16'h0001);

      // Enable hold.
      rst     = 1'b0;
      bus.in  = 16'h0000;
      bus.sel = 4'd3;
      tick();
      chk("capture_zero", 16'(bus.out_q), 16'h0000);
      bus.in  = 16'h8000;
      bus.sel = 4'd15;
      bus.en  = 1'b1;
      tick();
      chk("hold_capture", 16'(bus.out_q), 16'h0001);
      bus.en = 1'b0;
      bus.in = 16'h0000;
      #1;
      chk("hold_out_immediate", 16'(bus.out), 16'h0000);
      for (int n = 0; n < 3; n++) begin
         tick();
         chk($sformatf("hold_edge%0d", n), 16'(bus.out_q), 16'h0001);
      end

      // Reset mid-operation, then resume only once enabled.
      rst = 1'b1;
      tick();
      chk("mid_rst_clear", 16'(bus.out_q), 16'h0000);
      rst     = 1'b0;
      bus.in  = 16'hFFFF;
      bus.sel = 4'd3;
      tick();
      chk("mid_rst_hold_disabled", 16'(bus.out_q), 16'h0000);
      bus.en = 1'b1;
      tick();
      chk("mid_rst_resume", 16'(bus.out_q), 16'h0001);
      bus.in  = 16'h0040;
      bus.sel = 4'd6;
      tick();
      chk("capture_bit6", 16'(bus.out_q), 16'h0001);
      bus.sel = 4'd7;
      tick();
      chk("capture_bit7", 16'(bus.out_q), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
